// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions,
// exception codes and helpers that assemble the architectural register views.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_CPU  = 5'h0b,
    EXC_OV   = 5'h0c
  } exc_code_e;

  // Status as software sees it: BEV hard-wired to 1, unimplemented bits 0.
  function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                              input logic ie);
    logic [31:0] s;
    s = '0;
    s[STATUS_BEV] = 1'b1;
    s[STATUS_IM_LO +: 8] = im;
    s[STATUS_EXL] = exl;
    s[STATUS_IE] = ie;
    return s;
  endfunction

  // Cause as software sees it.
  function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                             input logic [7:0] ip, input logic [4:0] exccode);
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD] = bd;
    c[CAUSE_TI] = ti;
    c[CAUSE_IP_LO +: 8] = ip;
    c[CAUSE_EXC_LO +: 5] = exccode;
    return c;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Bus between the pipeline/exception controller (master) and the CP0
// register file (slave): MTC0/MFC0 access, exception-entry update, ERET.
interface cp0_regfile_if;

  logic        mtc0_ena;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        w_cp0_update_ena;
  logic [4:0]  w_cp0_exccode;
  logic        w_cp0_bd;
  logic        w_cp0_exl;
  logic [31:0] w_cp0_epc;
  logic        w_cp0_badvaddr_ena;
  logic [31:0] w_cp0_badvaddr;
  logic        w_cp0_entryhi_ena;
  logic [31:0] w_cp0_entryhi;
  logic        cp0_cls_exl;
  logic [31:0] r_cp0_epc;
  logic [31:0] r_cp0_status;
  logic [7:0]  r_cp0_entryhi_asid;

  modport master (
    output mtc0_ena, mtc0_addr, mtc0_data, mfc0_addr,
    output w_cp0_update_ena, w_cp0_exccode, w_cp0_bd, w_cp0_exl, w_cp0_epc,
    output w_cp0_badvaddr_ena, w_cp0_badvaddr, w_cp0_entryhi_ena, w_cp0_entryhi,
    output cp0_cls_exl,
    input  mfc0_data, r_cp0_epc, r_cp0_status, r_cp0_entryhi_asid
  );

  modport slave (
    input  mtc0_ena, mtc0_addr, mtc0_data, mfc0_addr,
    input  w_cp0_update_ena, w_cp0_exccode, w_cp0_bd, w_cp0_exl, w_cp0_epc,
    input  w_cp0_badvaddr_ena, w_cp0_badvaddr, w_cp0_entryhi_ena, w_cp0_entryhi,
    input  cp0_cls_exl,
    output mfc0_data, r_cp0_epc, r_cp0_status, r_cp0_entryhi_asid
  );

endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the
// sticky timer-interrupt flag TI.
module cp0_regfile_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;

  // Next state: software Count load restarts the prescaler; Compare write beats a match.
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/EntryHi storage, MFC0 read
// mux, exception-entry and ERET updates, and the interrupt request.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
  input  logic               clk,
  input  logic               rst_n,
  cp0_regfile_if.slave       bus,
  input  logic [5:0]         ext_int_i,
  output logic               cp0_int_req_o
);

  logic        mtc0_we;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_entryhi;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [18:0] vpn2_q, vpn2_d;
  logic [7:0]  asid_q, asid_d;
  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] status_w, cause_w, entryhi_w;
  logic        upd;

  assign upd        = bus.w_cp0_update_ena;
  assign mtc0_we    = bus.mtc0_ena & ~upd;
  assign wr_count   = mtc0_we & (bus.mtc0_addr == CP0_COUNT);
  assign wr_compare = mtc0_we & (bus.mtc0_addr == CP0_COMPARE);
  assign wr_status  = mtc0_we & (bus.mtc0_addr == CP0_STATUS);
  assign wr_cause   = mtc0_we & (bus.mtc0_addr == CP0_CAUSE);
  assign wr_epc     = mtc0_we & (bus.mtc0_addr == CP0_EPC);
  assign wr_entryhi = mtc0_we & (bus.mtc0_addr == CP0_ENTRYHI);

  cp0_regfile_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (bus.mtc0_data),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  assign status_w  = pack_status(im_q, exl_q, ie_q);
  assign cause_w   = pack_cause(bd_q, ti, {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q}, exccode_q);
  assign entryhi_w = {vpn2_q, 5'b0, asid_q};

  // Next state: exception entry wins over MTC0; ERET clears EXL last so it wins over MTC0 Status.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    exccode_d  = exccode_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    vpn2_d     = vpn2_q;
    asid_d     = asid_q;
    if (upd) begin
      exccode_d = bus.w_cp0_exccode;
      if (bus.w_cp0_exl) exl_d = 1'b1;
      if (!exl_q) begin
        epc_d = bus.w_cp0_epc;
        bd_d  = bus.w_cp0_bd;
      end
      if (bus.w_cp0_badvaddr_ena) badvaddr_d = bus.w_cp0_badvaddr;
      if (bus.w_cp0_entryhi_ena) vpn2_d = bus.w_cp0_entryhi[31:13];
    end else begin
      if (wr_status) begin
        im_d  = bus.mtc0_data[15:8];
        exl_d = bus.mtc0_data[1];
        ie_d  = bus.mtc0_data[0];
      end
      if (wr_cause) ip_sw_d = bus.mtc0_data[9:8];
      if (wr_epc) epc_d = bus.mtc0_data;
      if (wr_entryhi) begin
        vpn2_d = bus.mtc0_data[31:13];
        asid_d = bus.mtc0_data[7:0];
      end
      if (bus.cp0_cls_exl) exl_d = 1'b0;
    end
  end

  // Architectural register storage; ext_int is simply resampled every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      exccode_q  <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      exccode_q  <= exccode_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ext_int_i;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      vpn2_q     <= vpn2_d;
      asid_q     <= asid_d;
    end
  end

  // MFC0 read mux; unmapped numbers read 0.
  always_comb begin
    bus.mfc0_data = '0;
    case (bus.mfc0_addr)
      CP0_BADVADDR: bus.mfc0_data = badvaddr_q;
      CP0_COUNT:    bus.mfc0_data = count;
      CP0_ENTRYHI:  bus.mfc0_data = entryhi_w;
      CP0_COMPARE:  bus.mfc0_data = compare;
      CP0_STATUS:   bus.mfc0_data = status_w;
      CP0_CAUSE:    bus.mfc0_data = cause_w;
      CP0_EPC:      bus.mfc0_data = epc_q;
      CP0_PRID:     bus.mfc0_data = PRID_VALUE;
      default:      bus.mfc0_data = '0;
    endcase
  end

  // EPC forwarding lets an ERET directly after MTC0 EPC jump to the new target.
  assign bus.r_cp0_epc = (bus.mtc0_ena && (bus.mtc0_addr == CP0_EPC)) ? bus.mtc0_data : epc_q;
  assign bus.r_cp0_status       = status_w;
  assign bus.r_cp0_entryhi_asid = asid_q;
  assign cp0_int_req_o = ie_q & ~exl_q & (|(cause_w[15:8] & status_w[15:8]));

endmodule
